sti_pixel_packer: RTL and testbench
===================================

// Module: sti_pixel_packer
// PURPOSE
//  Downstream of the STI serializer: consumes its serial stream (so_data/so_valid) and repacks it into
//  MSB-first 8-bit pixels written sequentially into pixel memory. At end of stream it flushes any partial
//  byte, optionally zero-pads to DEPTH, then raises pixel_finish for the odd/even memory distributor.
// PARAMETERS
//  DEPTH   234  pixel memory depth (bytes); valid addresses 0..DEPTH-1
//  ADDR_W  8    pixel_addr width; DEPTH <= 2**ADDR_W
//  PAD_EN  0    1 = after the flush, write 8'h00 to every remaining address up to DEPTH-1
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high reset
//  so_data        in   1       serial bit, valid when so_valid=1
//  so_valid       in   1       one bit per cycle while high
//  pi_end         in   1       high: the word currently serialising is the last one
//  pixel_wr       out  1       one-cycle write strobe; addr/data stable while high
//  pixel_addr     out  ADDR_W  write address
//  pixel_dataout  out  8       write data
//  pixel_finish   out  1       sticky: all writes done
//  pixel_ovf      out  1       sticky: a byte completed with addr_cnt==DEPTH (byte dropped)
// BEHAVIOUR
//  Reset (async): all outputs 0, shift reg 0, bit_cnt 0, addr_cnt 0, state COLLECT.
//  COLLECT: each so_valid cycle: sh <= {sh[6:0],so_data}; bit_cnt++ (3-bit, wraps 7->0).
//   On the 8th bit (bit_cnt==7 & so_valid): next cycle pixel_wr=1, pixel_dataout={sh[6:0],so_data},
//   pixel_addr=addr_cnt; addr_cnt++. Latency: last bit sampled -> pixel_wr high exactly 1 cycle later.
//   If addr_cnt==DEPTH at completion: no strobe, addr_cnt holds, pixel_ovf <= 1.
//  End detect: so_valid_d=1 & so_valid=0 & pi_end=1 -> FLUSH. so_valid falling with pi_end=0 stays
//   in COLLECT with partial bit_cnt preserved (bytes span words).
//  FLUSH: bit_cnt!=0 -> one write of sh<<(8-bit_cnt) (zero-filled LSBs) at addr_cnt, addr_cnt++,
//   bit_cnt<=0; bit_cnt==0 -> no write. Then PAD if PAD_EN & addr_cnt<DEPTH, else DONE.
//  PAD: alternate strobe-high / strobe-low cycles writing 8'h00 at addr_cnt until addr DEPTH-1 written.
//  DONE: pixel_finish=1 from the cycle after the final write (or after FLUSH if none); held until reset.
//  pixel_wr is never high on two consecutive cycles (pixel memory latches on its rising edge).
//  so_valid in FLUSH/PAD/DONE: ignored, no state change.
//  Final write (flush or ovf drop) when addr_cnt==DEPTH: dropped, pixel_ovf=1, FLUSH proceeds to DONE.
//  Reset mid-operation: immediate abort; no strobe emitted after reset asserts.
//  pixel_addr/pixel_dataout hold last written values while pixel_wr=0.
// STRUCTURE
//  Package sti_pkg: state enum {COLLECT,FLUSH,PAD,DONE}; PIXEL_DEPTH=234; PIXEL_W=8.
//  Sub-module sti_byte_shifter: shift reg + bit_cnt, outputs byte_done, byte, partial count.
//  Top: FSM, address counter, strobe generation, sticky flags.
// TESTING
//  1) Stream 16 bits of 16'hA5C3 MSB-first, pi_end=1 -> A5@0, C3@1, no flush write, finish=1, ovf=0.
//  2) 12 bits 1011_0110_1101, pi_end=1 -> B6@0, D0@1 (flush), pixel_finish 1 cycle after last strobe.
//  3) Full 1872-bit stream (DEPTH=234) -> 234 writes, addrs 0..233 in order, ovf=0, finish=1.
//  4) PAD_EN=1, DEPTH=8, 24 bits -> 3 data writes, 8'h00 @3..7, strobes separated by low cycles.
//  5) DEPTH=2, 24 bits -> writes @0,@1 only; 3rd byte dropped, pixel_ovf=1, finish=1.
//  6) Reset asserted after 5 bits of a byte -> outputs 0 at once; restreamed 8'h3C lands @0.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared types and constants for the STI pixel packer.
package sti_pkg;

  localparam int PIXEL_DEPTH = 234;
  localparam int PIXEL_W     = 8;
  localparam int BIT_CNT_W   = 3;

  // Packer control states.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    PAD     = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Left-align a partial byte: the bits received so far sit in the LSBs of
  // the shift register, so move them to the MSBs and zero-fill the rest.
  function automatic logic [PIXEL_W-1:0] flush_align(
    input logic [PIXEL_W-1:0]   sh,
    input logic [BIT_CNT_W-1:0] cnt
  );
    return sh << (4'd8 - {1'b0, cnt});
  endfunction

endpackage

// File: rtl/sti_pixel_packer_if.sv
// Serial-in / pixel-memory-out bus of the packer. The master side is the
// packer itself (consumes the serial stream, drives the memory port); the
// slave side is whatever feeds the stream and observes the writes.
interface sti_pixel_packer_if #(
  parameter int ADDR_W = 8
);
  import sti_pkg::*;

  logic               so_data;
  logic               so_valid;
  logic               pi_end;
  logic               pixel_wr;
  logic [ADDR_W-1:0]  pixel_addr;
  logic [PIXEL_W-1:0] pixel_dataout;
  logic               pixel_finish;
  logic               pixel_ovf;

  modport master (
    input  so_data, so_valid, pi_end,
    output pixel_wr, pixel_addr, pixel_dataout, pixel_finish, pixel_ovf
  );

  modport slave (
    output so_data, so_valid, pi_end,
    input  pixel_wr, pixel_addr, pixel_dataout, pixel_finish, pixel_ovf
  );

endinterface

// File: rtl/sti_byte_shifter.sv
// MSB-first serial-to-byte shifter. Reports when the incoming bit completes
// a byte (combinationally, so the caller can register the write in the same
// edge) and offers the left-aligned partial byte for the end-of-stream flush.
module sti_byte_shifter
  import sti_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 bit_in,
  input  logic                 clear,
  output logic                 byte_done,
  output logic [PIXEL_W-1:0]   byte_val,
  output logic [PIXEL_W-1:0]   flush_val,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  logic [PIXEL_W-1:0] sh;

  // Shift one bit per qualified cycle; the bit counter wraps 7 -> 0 on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      // NOTE: non-blocking (<=) so every flop samples pre-edge values; blocking assignments here would make results depend on statement order.
      bit_cnt <= '0;
    end else if (shift_en) begin
      sh      <= {sh[PIXEL_W-2:0], bit_in};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // The eighth bit completes the byte; it is still on bit_in, not yet in sh.
  assign byte_done = shift_en && (&bit_cnt);
  assign byte_val  = {sh[PIXEL_W-2:0], bit_in};
  assign flush_val = flush_align(sh, bit_cnt);

endmodule

// File: rtl/sti_pixel_packer.sv
// Repacks the STI serial stream into MSB-first bytes written sequentially
// into pixel memory. At end of stream a partial byte is flushed, the memory
// is optionally zero-padded to DEPTH, and pixel_finish is raised.
module sti_pixel_packer
  import sti_pkg::*;
#(
  parameter int DEPTH  = PIXEL_DEPTH,
  parameter int ADDR_W = 8,
  parameter bit PAD_EN = 1'b0
) (
  input logic               clk,
  input logic               reset,
  sti_pixel_packer_if.master bus
);

  // addr_cnt is one bit wider than the address so it can sit at DEPTH
  // (memory full) without wrapping back to a valid address.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t               state;
  state_t               state_nxt;
  logic                 so_valid_d;
  logic [ADDR_W:0]      addr_cnt;
  logic [ADDR_W:0]      addr_after;
  logic                 room;
  logic                 end_det;
  logic                 wr_req;
  logic [PIXEL_W-1:0]   wr_data;
  logic                 drop;

  logic                 wr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [PIXEL_W-1:0]   data_q;
  logic                 finish_q;
  logic                 ovf_q;

  logic                 byte_done;
  logic [PIXEL_W-1:0]   byte_val;
  logic [PIXEL_W-1:0]   flush_val;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // Serial bits are only taken while collecting; later so_valid is ignored.
  sti_byte_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .shift_en  ((state == COLLECT) && bus.so_valid),
    .bit_in    (bus.so_data),
    .clear     (state == FLUSH),
    .byte_done (byte_done),
    .byte_val  (byte_val),
    .flush_val (flush_val),
    .bit_cnt   (bit_cnt)
  );

  assign room    = (addr_cnt < DEPTH_C);
  // Stream ends on a so_valid fall while pi_end marks the last word; a fall
  // without pi_end is just a gap between words and keeps the partial byte.
  assign end_det = (state == COLLECT) && so_valid_d && !bus.so_valid && bus.pi_end;

  // Delayed so_valid for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) so_valid_d <= 1'b0;
    else       so_valid_d <= bus.so_valid;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

  // Next state and the write request to register on this edge.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nxt  = state;
    wr_req     = 1'b0;
    wr_data    = '0;
    drop       = 1'b0;
    addr_after = addr_cnt;
    unique case (state)
      COLLECT: begin
        if (byte_done) begin
          if (room) begin
            wr_req  = 1'b1;
            wr_data = byte_val;
          end else begin
            drop = 1'b1;
          end
        end
        if (end_det) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (bit_cnt != '0) begin
          if (room) begin
            wr_req  = 1'b1;
            wr_data = flush_val;
          end else begin
            drop = 1'b1;
          end
        end
        // Padding decision must see the address after the flush write.
        addr_after = wr_req ? (addr_cnt + ONE_C) : addr_cnt;
        if (PAD_EN && (addr_after < DEPTH_C)) state_nxt = PAD;
        else                                  state_nxt = DONE;
      end
      PAD: begin
        if (!room) begin
          state_nxt = DONE;
        end else if (!wr_q) begin
          // Writing only when the strobe is low keeps a low cycle between
          // pad strobes, since memory latches on the strobe's rising edge.
          wr_req  = 1'b1;
          wr_data = '0;
          if (addr_cnt == LAST_C) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  // Write strobe, registered address/data (held between strobes), address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      addr_cnt <= '0;
    end else begin
      wr_q <= wr_req;
      if (wr_req) begin
        addr_q   <= addr_cnt[ADDR_W-1:0];
        data_q   <= wr_data;
        addr_cnt <= addr_cnt + ONE_C;
      end
    end
  end

  // Sticky status: overflow on any dropped byte, finish one cycle into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (drop)            ovf_q    <= 1'b1;
      if (state == DONE)   finish_q <= 1'b1;
    end
  end

  assign bus.pixel_wr      = wr_q;
  assign bus.pixel_addr    = addr_q;
  assign bus.pixel_dataout = data_q;
  assign bus.pixel_finish  = finish_q;
  assign bus.pixel_ovf     = ovf_q;

endmodule

// File: tb/tb_sti_pixel_packer.sv
// Bench for sti_pixel_packer: three configurations share one serial stream
// (234/no pad, 8/pad, 2/no pad) and each is compared against a byte-level
// reference model of the expected memory writes.
module tb_sti_pixel_packer;

  logic clk;
  logic reset;
  logic so_data;
  logic so_valid;
  logic pi_end;

  sti_pixel_packer_if #(.ADDR_W(8)) if0 ();
  sti_pixel_packer_if #(.ADDR_W(3)) if1 ();
  sti_pixel_packer_if #(.ADDR_W(2)) if2 ();

  assign if0.so_data = so_data;  assign if0.so_valid = so_valid;  assign if0.pi_end = pi_end;
  assign if1.so_data = so_data;  assign if1.so_valid = so_valid;  assign if1.pi_end = pi_end;
  assign if2.so_data = so_data;  assign if2.so_valid = so_valid;  assign if2.pi_end = pi_end;

  sti_pixel_packer #(.DEPTH(234), .ADDR_W(8), .PAD_EN(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0.master));
  sti_pixel_packer #(.DEPTH(8),   .ADDR_W(3), .PAD_EN(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.master));
  sti_pixel_packer #(.DEPTH(2),   .ADDR_W(2), .PAD_EN(1'b0)) u2 (.clk(clk), .reset(reset), .bus(if2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depth_of(input int i);
    case (i)
      0:       return 234;
      1:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic bit pad_of(input int i);
    return (i == 1);
  endfunction

  // Flattened views of the three output ports.
  logic [2:0] wr_s, fin_s, ovf_s;
  logic [7:0] addr_s [3];
  logic [7:0] data_s [3];
  assign wr_s  = {if2.pixel_wr,     if1.pixel_wr,     if0.pixel_wr};
  assign fin_s = {if2.pixel_finish, if1.pixel_finish, if0.pixel_finish};
  assign ovf_s = {if2.pixel_ovf,    if1.pixel_ovf,    if0.pixel_ovf};
  assign addr_s[0] = if0.pixel_addr;
  assign addr_s[1] = {5'd0, if1.pixel_addr};
  assign addr_s[2] = {6'd0, if2.pixel_addr};
  assign data_s[0] = if0.pixel_dataout;
  assign data_s[1] = if1.pixel_dataout;
  assign data_s[2] = if2.pixel_dataout;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Write log captured on the falling edge, away from the active edge.
  typedef struct {
    int inst;
    int addr;
    int data;
    int cyc;
  } wr_ev_t;

  wr_ev_t     ev_q[$];
  int         cyc = 0;
  int         fin_cyc [3];
  logic [2:0] prev_wr;
  logic [2:0] b2b;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      ev_q.delete();
      prev_wr = '0;
      b2b     = '0;
      for (int i = 0; i < 3; i++) fin_cyc[i] = -1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr_s[i]) begin
          ev_q.push_back('{inst: i, addr: int'(addr_s[i]), data: int'(data_s[i]), cyc: cyc});
          if (prev_wr[i]) b2b[i] = 1'b1;
        end
        if (fin_s[i] && fin_cyc[i] < 0) fin_cyc[i] = cyc;
        prev_wr[i] = wr_s[i];
      end
    end
  end

  bit stream_q[$];

  task automatic load_word(input int n, input logic [31:0] w);
    stream_q.delete();
    for (int i = n - 1; i >= 0; i--) stream_q.push_back(w[i]);
  endtask

  task automatic load_random(input int n);
    stream_q.delete();
    for (int i = 0; i < n; i++) stream_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    so_valid = 1'b0;
    so_data  = 1'b0;
    pi_end   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Send stream_q, optionally split into random words with gaps; pi_end is
  // high only across the last word and the falling edge that ends it.
  task automatic send_stream(input bit split, input bit close);
    int idx;
    int len;
    int gap;
    bit last;
    idx = 0;
    while (idx < stream_q.size()) begin
      len = split ? int'($urandom_range(1, 20)) : stream_q.size();
      if (idx + len > stream_q.size()) len = stream_q.size() - idx;
      last = (idx + len == stream_q.size());
      for (int k = 0; k < len; k++) begin
        @(posedge clk); #1;
        so_valid = 1'b1;
        so_data  = stream_q[idx + k];
        pi_end   = last && close;
      end
      idx += len;
      if (!last) begin
        gap = split ? int'($urandom_range(0, 3)) : 0;
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          so_valid = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    so_valid = 1'b0;
    pi_end   = close;
    @(posedge clk); #1;
    pi_end = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (fin_s != 3'b111 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s/finish", name), int'(fin_s), 7);
  endtask

  // Reference: the stream cut into 8-bit MSB-first groups (last one
  // zero-filled), the first DEPTH kept, zero-padded to DEPTH when enabled.
  task automatic check_inst(input string name, input int i);
    int     n, nb, dep, kept, j, last_cyc, val;
    bit     pad, tight;
    logic [7:0] exp_q[$];
    n   = stream_q.size();
    dep = depth_of(i);
    pad = pad_of(i);
    nb  = (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      val = 0;
      for (int k = 0; k < 8; k++)
        val = val * 2 + ((8 * b + k < n) ? int'(stream_q[8 * b + k]) : 0);
      if (b < dep) exp_q.push_back(8'(val));
    end
    kept = exp_q.size();
    if (pad) while (exp_q.size() < dep) exp_q.push_back(8'h00);
    // Final write is a flush or a pad write: finish follows it by one cycle.
    tight = (pad && kept < dep) || ((n % 8 != 0) && nb <= dep);
    j = 0;
    last_cyc = -1;
    foreach (ev_q[e]) begin
      if (ev_q[e].inst == i) begin
        if (j < exp_q.size()) begin
          check($sformatf("%s/u%0d/addr%0d", name, i, j), ev_q[e].addr, j);
          check($sformatf("%s/u%0d/data%0d", name, i, j), ev_q[e].data, int'(exp_q[j]));
        end
        j++;
        last_cyc = ev_q[e].cyc;
      end
    end
    check($sformatf("%s/u%0d/writes", name, i), j, exp_q.size());
    check($sformatf("%s/u%0d/ovf", name, i), int'(ovf_s[i]), int'(nb > dep));
    check($sformatf("%s/u%0d/no_b2b", name, i), int'(b2b[i]), 0);
    if (exp_q.size() > 0) begin
      check($sformatf("%s/u%0d/hold_addr", name, i), int'(addr_s[i]), exp_q.size() - 1);
      check($sformatf("%s/u%0d/hold_data", name, i), int'(data_s[i]), int'(exp_q[exp_q.size() - 1]));
    end
    if (tight) check($sformatf("%s/u%0d/fin_gap", name, i), fin_cyc[i] - last_cyc, 1);
    else       check($sformatf("%s/u%0d/fin_after", name, i), int'(fin_cyc[i] > last_cyc), 1);
  endtask

  task automatic run_case(input string name, input bit split);
    do_reset();
    check($sformatf("%s/reset_flags", name), int'({fin_s, ovf_s, wr_s}), 0);
    send_stream(split, 1'b1);
    wait_done(name);
    for (int i = 0; i < 3; i++) check_inst(name, i);
  endtask

  initial begin
    reset    = 1'b1;
    so_valid = 1'b0;
    so_data  = 1'b0;
    pi_end   = 1'b0;

    load_word(16, 32'h0000_A5C3);
    run_case("a5c3", 1'b0);

    load_word(12, 32'b1011_0110_1101);
    run_case("b6_d0", 1'b0);

    load_random(1872);
    run_case("full", 1'b1);

    load_random(24);
    run_case("bits24", 1'b1);

    for (int r = 0; r < 6; r++) begin
      load_random(int'($urandom_range(1, 40)));
      run_case($sformatf("rand%0d", r), 1'b1);
    end

    // Abort after two bytes and five bits of a third: outputs clear at once.
    do_reset();
    load_word(21, 32'h0014_B8F5);
    send_stream(1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort/u%0d/wr", i),   int'(wr_s[i]),   0);
      check($sformatf("abort/u%0d/addr", i), int'(addr_s[i]), 0);
      check($sformatf("abort/u%0d/data", i), int'(data_s[i]), 0);
      check($sformatf("abort/u%0d/flags", i), int'({fin_s[i], ovf_s[i]}), 0);
    end
    load_word(8, 32'h0000_003C);
    run_case("restream", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
